// File: rtl/cont_mod10.sv
// Decade (modulo-MODULUS) up-counter with combinational terminal-count flag.
// Counts on every rising clk edge; asynchronous active-high reset.
`timescale 1ns/1ps
module cont_mod10 #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cont,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cont_q;
  logic [WIDTH-1:0] cont_d;

  // ">=" also folds any forced out-of-range value back to 0 on the next edge.
  always_comb begin
    cont_d = cont_q + WIDTH'(1);
    if (cont_q >= LAST) begin
      cont_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign cont = cont_q;
  assign tc   = (cont_q == LAST);

endmodule

// File: tb/tb_cont_mod10.sv
// Directed self-checking bench for cont_mod10 (default decade and MODULUS=6).
`timescale 1ns/1ps
module tb_cont_mod10;

  logic       clk;
  logic       rst;
  logic [3:0] cont;
  logic       tc;
  logic [2:0] cont6;
  logic       tc6;

  int checks = 0;
  int errors = 0;
  int half   = 5;

  cont_mod10 dut (
    .clk (clk),
    .rst (rst),
    .cont(cont),
    .tc  (tc)
  );

  cont_mod10 #(.MODULUS(6), .WIDTH(3)) dut6 (
    .clk (clk),
    .rst (rst),
    .cont(cont6),
    .tc  (tc6)
  );

  initial begin
    clk = 1'b0;
    forever #(half) clk = ~clk;
  end

  task automatic test_reset();
    #1;
    checks++;
    if (cont !== 4'd0) begin errors++; $display("FAIL reset_pre_edge cont got %0d want 0", cont); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_pre_edge tc got %b want 0", tc); end
    checks++;
    if (cont6 !== 3'd0) begin errors++; $display("FAIL reset_pre_edge cont6 got %0d want 0", cont6); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cont !== 4'd0 || tc !== 1'b0) begin
        errors++; $display("FAIL reset_hold edge %0d cont got %0d tc %b want 0 0", i, cont, tc);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp;
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = 4'(i % 10);
      checks++;
      if (cont !== exp) begin errors++; $display("FAIL count edge %0d cont got %0d want %0d", i, cont, exp); end
      checks++;
      if (tc !== (exp == 4'd9)) begin errors++; $display("FAIL tc edge %0d got %b want %b", i, tc, exp == 4'd9); end
    end
  endtask

  task automatic test_mid_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cont !== 4'd5) begin errors++; $display("FAIL mid_setup cont got %0d want 5", cont); end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (cont !== 4'd0) begin errors++; $display("FAIL mid_async cont got %0d want 0", cont); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cont !== 4'd0) begin errors++; $display("FAIL mid_hold edge %0d cont got %0d want 0", i, cont); end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cont !== 4'd1) begin errors++; $display("FAIL mid_release cont got %0d want 1", cont); end
  endtask

  task automatic test_long_run();
    int pulses;
    logic [3:0] exp;
    pulses = 0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      exp = 4'(n % 10);
      checks++;
      if (cont !== exp) begin errors++; $display("FAIL long edge %0d cont got %0d want %0d", n, cont, exp); end
      if (tc === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 10) begin errors++; $display("FAIL long_tc_pulses got %0d want 10", pulses); end
  endtask

  task automatic test_param6();
    logic [2:0] exp;
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (cont6 !== 3'd0 || tc6 !== 1'b0) begin
      errors++; $display("FAIL p6_reset cont6 got %0d tc6 %b want 0 0", cont6, tc6);
    end
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      exp = 3'(n % 6);
      checks++;
      if (cont6 !== exp) begin errors++; $display("FAIL p6 edge %0d cont6 got %0d want %0d", n, cont6, exp); end
      checks++;
      if (tc6 !== (exp == 3'd5)) begin errors++; $display("FAIL p6_tc edge %0d got %b want %b", n, tc6, exp == 3'd5); end
    end
  endtask

  task automatic test_short_release();
    logic [3:0] maxc;
    maxc = 4'd0;
    half = 1;
    repeat (6) @(posedge clk);
    #0.5 rst = 1'b1;
    #6   rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (cont > maxc) maxc = cont;
    end
    rst = 1'b1;
    checks++;
    if (maxc < 4'd1 || maxc > 4'd2) begin
      errors++; $display("FAIL short_window max cont got %0d want 1..2", maxc);
    end
    #0.2;
    checks++;
    if (cont !== 4'd0) begin errors++; $display("FAIL short_async cont got %0d want 0", cont); end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (cont !== 4'd0) begin errors++; $display("FAIL short_hold step %0d cont got %0d want 0", k, cont); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_count_wrap();
    test_mid_reset();
    test_long_run();
    test_param6();
    test_short_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
